instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: encodes instruction field sets into 21-bit words and writes them to instruction memory
// Ports:
//   clk, rst_n           single clock, synchronous active-low reset
//   start, finish        open a load session (IDLE only) / close it early (LOAD only)
//   in_valid, in_ready   handshake for one instruction field set
//   in_op .. in_target   raw opcode and the R/I/J fields
//   mem_we, mem_addr,    registered instruction-memory write port
//   mem_wdata
//   busy, done           session in progress / one-cycle completion pulse
//   word_cnt, err        words written this session / sticky illegal-opcode flag
module instr_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [3:0]        in_funct,
    input  logic [9:0]        in_imm,
    input  logic [15:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [20:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              err
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [20:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W+1:0] fill;
    logic              legal, accept, last;
    logic [20:0]       enc;

    always_comb begin
        legal = 1'b1;
        enc   = {in_op, in_rs, in_rt, in_imm};
        case (in_op)
            5'b00000: enc = {in_op, in_rs, in_rt, in_rd, 3'b000, in_funct};
            5'b00111: enc = {in_op, in_target};
            5'b00100, 5'b10010, 5'b11000,
            5'b01000, 5'b01100, 5'b01111: enc = {in_op, in_rs, in_rt, in_imm};
            default: begin
                legal = 1'b0;
                enc   = '0;
            end
        endcase
    end

    // words claimed this session: those already written plus the one in the write register
    assign fill     = {1'b0, cnt_q} + {{(ADDR_W+1){1'b0}}, we_q};
    assign in_ready = (state_q == LOAD) && (fill < (ADDR_W+2)'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign last     = accept && legal && (fill == (ADDR_W+2)'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        // the write presented this cycle retires at the edge; the address saturates instead of wrapping
        if (we_q) begin
            addr_d = (&addr_q) ? addr_q : addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept && legal) begin
                    we_d    = 1'b1;
                    wdata_d = enc;
                end
                if (accept && !legal) err_d = 1'b1;
                if (finish || last) state_d = FLUSH;
            end
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == LOAD) || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign word_cnt  = cnt_q;
    assign err       = err_q;
endmodule
